simplez_mem_arbiter: RTL

- Shares the single-port Simplez RAM (synchronous read, `rw`=1 read / 0 write) between two requesters:
  - port 0: the CPU control unit;
  - port 1: the program loader / debug port.
- Sits between the requesters and the RAM instance and sequences every access through a fixed 3-state FSM.
- Arbitration is round-robin, with an optional lock for port 1 so the loader can stream consecutive accesses.

---
 rtl/simplez_defs.sv | 14 +
 rtl/rr_pick2.sv | 18 +
 rtl/simplez_mem_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/simplez_defs.sv
// Shared constants and FSM encoding for the Simplez RAM arbiter.
package simplez_defs;
    localparam int AW_DEF = 9;
    localparam int DW_DEF = 12;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin tie-break. A lock lets port 1 keep winning ties while it was the last one served.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock,
    output logic [1:0] win
);
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            // last=1 means port 1 was served most recently
            2'b11:   win = (last && !lock) ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end
endmodule

// File: rtl/simplez_mem_arbiter.sv
// Two-port arbiter for the single-port Simplez RAM; every access runs IDLE -> ACCESS -> RESP.
module simplez_mem_arbiter
    import simplez_defs::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          r0_req,
    input  logic          r0_rw,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_rw,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    input  logic          r1_lock,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rw,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic [1:0]    gnt,
    output logic          busy
);
    state_t        state, state_nxt;
    logic [1:0]    win;
    logic [1:0]    gnt_q;
    logic          last_q;
    logic          lat_rw;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rd0_q, rd1_q;
    logic          rd_resp;

    rr_pick2 u_pick (
        .req  ({r1_req, r0_req}),
        .last (last_q),
        .lock (r1_lock),
        .win  (win)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|win) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            gnt_q     <= 2'b00;
            last_q    <= 1'b1;
            lat_rw    <= RW_READ;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (|win) begin
                    gnt_q     <= win;
                    lat_rw    <= win[1] ? r1_rw    : r0_rw;
                    lat_addr  <= win[1] ? r1_addr  : r0_addr;
                    lat_wdata <= win[1] ? r1_wdata : r0_wdata;
                end
                RESP: begin
                    last_q <= gnt_q[1];
                    gnt_q  <= 2'b00;
                    if (lat_rw == RW_READ) begin
                        if (gnt_q[0]) rd0_q <= mem_dout;
                        if (gnt_q[1]) rd1_q <= mem_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM read data arrives during RESP; pass it straight through for the ack cycle, then hold it.
    assign rd_resp  = (state == RESP) && (lat_rw == RW_READ);
    assign r0_ack   = (state == RESP) && gnt_q[0];
    assign r1_ack   = (state == RESP) && gnt_q[1];
    assign r0_rdata = (r0_ack && rd_resp) ? mem_dout : rd0_q;
    assign r1_rdata = (r1_ack && rd_resp) ? mem_dout : rd1_q;

    assign mem_addr = lat_addr;
    assign mem_din  = lat_wdata;
    assign mem_rw   = (state == ACCESS) ? lat_rw : RW_READ;
    assign gnt      = gnt_q;
    assign busy     = (state != IDLE);
endmodule
